// File: rtl/bos_pkg.sv
// Shared definitions for the response arbiter: parameter defaults, state encoding, index width.
// Defining RESP_CHECKSUM_EN adds the CSUM state.
package bos_pkg;

  localparam int unsigned NSrcDefault     = 25;
  localparam logic [7:0]  SyncByteDefault = 8'hA5;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StSync = 3'd1,
    StAddr = 3'd2,
    StLen  = 3'd3,
    StData = 3'd4
`ifdef RESP_CHECKSUM_EN
    , StCsum = 3'd5
`endif
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search: picks the first set request bit after index `last`, wrapping at N.
module rr_arbiter
  import bos_pkg::*;
#(
  parameter int unsigned N = NSrcDefault,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant,
  output logic          any_req
);

  always_comb begin
    int unsigned idx;
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    // i runs 1..N so `last` itself is checked last
    for (int unsigned i = 1; i <= N; i++) begin
      idx = 32'(last) + i;
      if (idx >= N) idx = idx - N;
      if (!any_req && req[IW'(idx)]) begin
        any_req = 1'b1;
        grant   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/resp_arbiter.sv
// Packetizing response arbiter: round-robin grant over N_SRC sources, emits SYNC/ADDR/LEN/payload
// bytes to a UART. Defining RESP_CHECKSUM_EN appends a modulo-256 checksum byte.
module resp_arbiter
  import bos_pkg::*;
#(
  parameter int unsigned N_SRC     = NSrcDefault,
  parameter logic [7:0]  SYNC_BYTE = SyncByteDefault
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [N_SRC-1:0]     have_msg_bus,
  input  logic [8*N_SRC-1:0]   data_bus,
  input  logic [8*N_SRC-1:0]   len_bus,
  output logic [N_SRC-1:0]     rdreq_bus,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);

  localparam int unsigned IW = idx_width(N_SRC);

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [IW-1:0] arb_grant;
  logic          arb_any;
  logic          body_done;

  logic [7:0] data_arr [N_SRC];
  logic [7:0] len_arr  [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign data_arr[i] = data_bus[8*i +: 8];
    assign len_arr[i]  = len_bus[8*i +: 8];
  end

  rr_arbiter #(
    .N (N_SRC)
  ) u_rr_arbiter (
    .req     (have_msg_bus),
    .last    (last_q),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

`ifdef RESP_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == StIdle) begin
      csum_d = 8'h00;
    end else if (tx_ready && (state_q inside {StAddr, StLen, StData})) begin
      csum_d = csum_q + tx_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) csum_q <= 8'h00;
    else        csum_q <= csum_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    body_done = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    rdreq_bus = '0;

    case (state_q)
      StIdle: begin
        cnt_d = 8'h00;
        if (arb_any) begin
          grant_d = arb_grant;
          len_d   = len_arr[arb_grant];
          state_d = StSync;
        end
      end
      StSync: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (tx_ready) state_d = StAddr;
      end
      StAddr: begin
        tx_valid = 1'b1;
        tx_data  = 8'(grant_q);
        if (tx_ready) state_d = StLen;
      end
      StLen: begin
        tx_valid = 1'b1;
        tx_data  = len_q;
        if (tx_ready) begin
          if (len_q == 8'h00) body_done = 1'b1;
          else                state_d   = StData;
        end
      end
      StData: begin
        tx_valid = 1'b1;
        tx_data  = data_arr[grant_q];
        if (tx_ready) begin
          rdreq_bus[grant_q] = 1'b1;
          if (cnt_q == len_q - 8'd1) begin
            body_done = 1'b1;
            cnt_d     = 8'h00;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
`ifdef RESP_CHECKSUM_EN
      StCsum: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (tx_ready) begin
          state_d = StIdle;
          last_d  = grant_q;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (body_done) begin
`ifdef RESP_CHECKSUM_EN
      state_d = StCsum;
`else
      state_d = StIdle;
      last_d  = grant_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IW'(N_SRC - 1);
      len_q   <= 8'h00;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_resp_arbiter.sv
// Randomized scoreboard bench for resp_arbiter: queue-based sources, packet-level reference model.
module tb_resp_arbiter;

  localparam int unsigned NS   = 25;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [NS-1:0]     have_msg_bus;
  logic [8*NS-1:0]   data_bus;
  logic [8*NS-1:0]   len_bus;
  logic [NS-1:0]     rdreq_bus;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  always #5 clk = ~clk;

  resp_arbiter #(
    .N_SRC     (NS),
    .SYNC_BYTE (SYNC)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .have_msg_bus (have_msg_bus),
    .data_bus     (data_bus),
    .len_bus      (len_bus),
    .rdreq_bus    (rdreq_bus),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  // Source model: pending packet lengths and concatenated payload bytes per source
  logic [7:0] plen_q [NS][$];
  logic [7:0] pdat_q [NS][$];

  typedef struct {
    logic [7:0] b;
    bit         pay;
  } exp_t;
  exp_t exp_q[$];

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  bit          in_pkt = 0;
  int unsigned m_grant = 0, m_last = NS - 1, m_len = 0, pay_seen = 0, pk_rd = 0;
  logic [NS-1:0] rd_pend = '0;
  bit          drop_valid = 0;
  int unsigned drop_src = 0;
  bit          timeout_req = 0, timeout_seen = 0;
  int unsigned rdy_mode = 0;
  int unsigned cyc = 0;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, want, $time);
    end
  endfunction

  function automatic void start_pkt(input int unsigned s);
    logic [7:0] sum;
    m_grant = s;
    m_len   = plen_q[s][0];
    sum     = 8'(s) + 8'(m_len);
    exp_q.push_back('{SYNC, 1'b0});
    exp_q.push_back('{8'(s), 1'b0});
    exp_q.push_back('{8'(m_len), 1'b0});
    for (int j = 0; j < int'(m_len); j++) begin
      exp_q.push_back('{pdat_q[s][j], 1'b1});
      sum = sum + pdat_q[s][j];
    end
`ifdef RESP_CHECKSUM_EN
    exp_q.push_back('{sum, 1'b0});
`endif
    in_pkt   = 1;
    pay_seen = 0;
    pk_rd    = 0;
  endfunction

  function automatic void decide();
    for (int unsigned k = 1; k <= NS; k++) begin
      int unsigned s;
      s = (m_last + k) % NS;
      if (plen_q[s].size() > 0) begin
        start_pkt(s);
        return;
      end
    end
  endfunction

  // Monitor: compares every cycle at the falling edge, pops the scoreboard on each accepted byte
  initial begin : monitor
    logic [NS-1:0] rd_exp;
    forever begin
      @(negedge clk);
      rd_pend    = '0;
      drop_valid = 0;
      if (timeout_req && !timeout_seen) begin
        timeout_seen = 1;
        chk("drain_timeout", 32'd1, 32'd0);
      end
      if (!n_rst) begin
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_rdreq", 32'(rdreq_bus), 32'd0);
        exp_q.delete();
        in_pkt = 0;
        m_last = NS - 1;
      end else if (in_pkt) begin
        chk("tx_valid_in_pkt", 32'(tx_valid), 32'd1);
        chk("tx_data", 32'(tx_data), 32'(exp_q[0].b));
        rd_exp = '0;
        if (tx_ready && exp_q[0].pay) rd_exp[m_grant] = 1'b1;
        chk("rdreq", 32'(rdreq_bus), 32'(rd_exp));
        rd_pend = rdreq_bus;
        if (rdreq_bus[m_grant]) pk_rd++;
        if (tx_ready) begin
          if (exp_q[0].pay) pay_seen++;
          exp_q.delete(0);
          if (exp_q.size() == 0) begin
            in_pkt = 0;
            chk("rd_pulses", pk_rd, m_len);
            m_last     = m_grant;
            drop_valid = 1;
            drop_src   = m_grant;
          end
        end
      end else begin
        chk("idle_tx_valid", 32'(tx_valid), 32'd0);
        chk("idle_rdreq", 32'(rdreq_bus), 32'd0);
        rd_pend = rdreq_bus;
        decide();
      end
    end
  end

  task automatic drive_buses();
    for (int i = 0; i < NS; i++) begin
      have_msg_bus[i]    = plen_q[i].size() > 0;
      len_bus[8*i +: 8]  = (plen_q[i].size() > 0) ? plen_q[i][0] : 8'h00;
      data_bus[8*i +: 8] = (pdat_q[i].size() > 0) ? pdat_q[i][0] : 8'h00;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (rd_pend[i] && pdat_q[i].size() > 0) pdat_q[i].delete(0);
    end
    if (drop_valid && plen_q[drop_src].size() > 0) plen_q[drop_src].delete(0);
    cyc++;
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
    drive_buses();
  endtask

  task automatic inject(input int unsigned s, input int unsigned len);
    plen_q[s].push_back(8'(len));
    for (int j = 0; j < int'(len); j++) pdat_q[s].push_back(8'($urandom_range(0, 255)));
    drive_buses();
  endtask

  task automatic flush();
    for (int i = 0; i < NS; i++) begin
      plen_q[i].delete();
      pdat_q[i].delete();
    end
    drive_buses();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NS; i++) if (plen_q[i].size() > 0) return 0;
    return 1;
  endfunction

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (!in_pkt && all_empty()) return;
      step();
    end
    timeout_req = 1;
    step();
    step();
  endtask

  initial begin : driver
    bit hit;
    n_rst        = 1'b0;
    tx_ready     = 1'b1;
    have_msg_bus = '0;
    data_bus     = '0;
    len_bus      = '0;
    repeat (3) step();
    n_rst = 1'b1;

    // Source 3, fixed payload 11,22
    plen_q[3].push_back(8'd2);
    pdat_q[3].push_back(8'h11);
    pdat_q[3].push_back(8'h22);
    drive_buses();
    wait_drain(100);

    // Simultaneous 0,5,24 from reset, then 0 and 24 again
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    inject(0, 3);
    inject(5, 2);
    inject(24, 1);
    wait_drain(200);
    inject(0, 2);
    inject(24, 3);
    wait_drain(200);

    // Back-pressure pattern 1-0-0-1
    rdy_mode = 1;
    inject(1, 6);
    wait_drain(200);
    rdy_mode = 0;

    // Zero-length payload
    inject(7, 0);
    wait_drain(50);

    // Reset during 2nd payload byte; priority restarts at source 0
    inject(2, 4);
    hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      step();
      if (in_pkt && m_grant == 2 && pay_seen == 1) hit = 1;
    end
    if (!hit) timeout_req = 1;
    #1;
    n_rst = 1'b0;
    flush();
    inject(3, 2);
    inject(0, 1);
    step();
    step();
    n_rst = 1'b1;
    wait_drain(100);

    // Maximum length
    inject(24, 255);
    wait_drain(600);

    // Random traffic with random back-pressure
    rdy_mode = 2;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        inject($urandom_range(0, NS - 1),
               ($urandom_range(0, 7) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 5));
      end
      step();
    end
    wait_drain(4000);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/resp_arbiter.md
RESP_ARBITER -- requirements
Module: resp_arbiter

Interface
REQ-001 Parameter N_SRC, default 25: number of response sources; legal range 2..256.
REQ-002 Parameter SYNC_BYTE, default 8'hA5: first byte of every outgoing packet.
REQ-003 clk  in  1  system clock; one clock only.
REQ-004 n_rst  in  1  asynchronous, active-low reset.
REQ-005 have_msg_bus  in  N_SRC  per-source flag: response pending.
REQ-006 data_bus  in  8*N_SRC  per-source show-ahead byte; slice i is [8*i+:8].
REQ-007 len_bus  in  8*N_SRC  per-source payload length in bytes (0..255); valid while have_msg is high.
REQ-008 rdreq_bus  out  N_SRC  per-source one-cycle pop strobe.
REQ-009 tx_data  out  8  byte to UART.
REQ-010 tx_valid  out  1  tx_data valid.
REQ-011 tx_ready  in  1  UART accepts byte.

Function
REQ-012 Packet format: SYNC_BYTE, ADDR (granted source index), LEN (latched len), LEN payload bytes, then optional CSUM (see REQ-026).
REQ-013 States: IDLE, SYNC, ADDR, LEN, DATA, CSUM.
REQ-014 IDLE: if any have_msg bit is set, grant the first set bit searching from (last_grant+1) mod N_SRC upward with wrap-around; latch grant and len; go to SYNC next cycle.
REQ-015 Latency: have_msg sampled high in IDLE at cycle N -> tx_valid=1 with SYNC_BYTE at cycle N+1.
REQ-016 In SYNC/ADDR/LEN/DATA/CSUM, tx_valid=1 and tx_data is driven from the state, the latched fields, or data_bus[grant].
REQ-017 Each byte advances only on tx_valid & tx_ready; tx_data is held stable while tx_ready=0.
REQ-018 DATA: rdreq_bus[grant] = tx_valid & tx_ready; all other rdreq bits are 0; rdreq never asserts outside DATA.
REQ-019 An 8-bit byte counter counts payload bytes accepted; leave DATA after the byte at which counter = len-1 is accepted.
REQ-020 LEN=0: go from LEN directly to CSUM (or IDLE); no rdreq is issued.
REQ-021 After the final byte, return to IDLE and set last_grant := grant; the next grant is decided in IDLE one cycle later.
REQ-022 have_msg_bus and len_bus changes during a packet are ignored until IDLE.
REQ-023 Simultaneous requests are served strictly round-robin: no source is served twice while another requesting source waits.
REQ-024 tx_valid is never deasserted mid-packet.

Reset
REQ-025 While n_rst=0: state=IDLE, tx_valid=0, tx_data=0, rdreq_bus=0, counter=0, last_grant=N_SRC-1 (source 0 has first priority). Reset mid-packet aborts the packet with no further rdreq.

Configuration
REQ-026 Macro RESP_CHECKSUM_EN defined: the CSUM state sends the 8-bit modulo-256 sum of ADDR, LEN and all payload bytes, and the accumulator clears in IDLE. Macro undefined: no CSUM state or accumulator; the packet ends after the last payload byte (or after LEN when LEN=0).

Structure
REQ-027 The shared package (bos_pkg) holds the SYNC_BYTE default, the state encoding and the N_SRC default.
REQ-028 The round-robin grant search is a separate sub-module rr_arbiter (parameter N; inputs req and last; outputs grant index and any_req).

Verification
REQ-029 Source 3, len=2, data 0x11,0x22, tx_ready=1 -> A5,03,02,11,22 (+CSUM 0x38 if enabled); rdreq_bus[3] high exactly 2 cycles.
REQ-030 Sources 0, 5 and 24 requesting at once from reset -> packets in order 0, 5, 24; then with 0 and 24 re-requesting -> 0, 24.
REQ-031 tx_ready toggles 1-0-0-1 during DATA -> tx_data held, no extra rdreq, payload intact.
REQ-032 Source 7, len=0 -> A5,07,00 (+CSUM 0x07 if enabled); zero rdreq pulses.
REQ-033 n_rst pulsed low during 2nd payload byte of a len=4 packet -> tx_valid=0 immediately, state IDLE, next grant searches from source 0.
REQ-034 Source 24, len=255 -> exactly 255 rdreq pulses; counter wrap does not add bytes.
